// File: rtl/board_clock_ctrl.sv
// Board clock front end: one-cycle CPU enable (halt/step/divide/full), switch sync+debounce, LED register.
// cpu_en, switch, led, en_count are registered (1 cycle); no backpressure, every input is consumed each cycle.
module board_clock_ctrl #(
   parameter int DIV_WIDTH       = 24,
   parameter int DEFAULT_DIV     = 5000000,
   parameter int N_SW            = 4,
   parameter int N_LED           = 4,
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [1:0]           mode,
   input  logic                 div_load,
   input  logic [DIV_WIDTH-1:0] div_value,
   input  logic                 step_btn,
   input  logic [N_SW-1:0]      switch_raw,
   input  logic [N_LED-1:0]     led_in,
   output logic                 cpu_en,
   output logic [N_SW-1:0]      switch,
   output logic [N_LED-1:0]     led,
   output logic [31:0]          en_count
);

   typedef enum logic [1:0] {
      MODE_HALT = 2'b00,
      MODE_STEP = 2'b01,
      MODE_DIV  = 2'b10,
      MODE_FULL = 2'b11
   } mode_e;

   // Bit 0 of the synchronised/debounced vectors is the step button.
   localparam int NB  = N_SW + 1;
   localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

   logic [NB-1:0]        sync1;
   logic [NB-1:0]        sync2;
   logic [NB-1:0]        deb;
   logic [DBW-1:0]       db_cnt [NB];
   logic                 step_prev;
   logic                 step_edge;
   logic [1:0]           mode_prev;
   logic                 mode_chg;
   logic [DIV_WIDTH-1:0] div_reg;
   logic [DIV_WIDTH-1:0] div_cnt;
   logic [DIV_WIDTH-1:0] div_cnt_nxt;
   logic                 div_hit;
   logic                 cpu_en_nxt;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1     <= '0;
         sync2     <= '0;
         deb       <= '0;
         step_prev <= 1'b0;
         for (int i = 0; i < NB; i++) begin
            db_cnt[i] <= '0;
         end
      end else begin
         sync1     <= {switch_raw, step_btn};
         sync2     <= sync1;
         step_prev <= deb[0];
         for (int i = 0; i < NB; i++) begin
            if (sync2[i] == deb[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               deb[i]    <= sync2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + DBW'(1);
            end
         end
      end
   end

   // Reset captures the live mode so leaving reset is not seen as a mode change.
   always_ff @(posedge clk) begin
      mode_prev <= mode;
   end

   assign step_edge = deb[0] & ~step_prev;
   assign mode_chg  = (mode != mode_prev);
   assign div_hit   = (div_cnt == div_reg - DIV_WIDTH'(1));

   always_comb begin
      cpu_en_nxt  = 1'b0;
      div_cnt_nxt = '0;
      case (mode_e'(mode))
         MODE_STEP: cpu_en_nxt = step_edge;
         MODE_DIV: begin
            if (!div_load) begin
               if (div_hit) begin
                  cpu_en_nxt = 1'b1;
               end else begin
                  div_cnt_nxt = div_cnt + DIV_WIDTH'(1);
               end
            end
         end
         MODE_FULL: cpu_en_nxt = 1'b1;
         default: cpu_en_nxt = 1'b0;
      endcase
      if (mode_chg) begin
         cpu_en_nxt  = 1'b0;
         div_cnt_nxt = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cpu_en   <= 1'b0;
         div_reg  <= DIV_WIDTH'(DEFAULT_DIV);
         div_cnt  <= '0;
         en_count <= '0;
         led      <= '0;
      end else begin
         cpu_en  <= cpu_en_nxt;
         div_cnt <= div_cnt_nxt;
         led     <= led_in;
         if (div_load) begin
            div_reg <= (div_value == '0) ? DIV_WIDTH'(1) : div_value;
         end
         if (cpu_en) begin
            en_count <= en_count + 32'd1;
         end
      end
   end

   assign switch = deb[NB-1:1];

endmodule

// File: tb/tb_board_clock_ctrl.sv
// Randomised and directed stimulus against a history-based reference model; scoreboard queue checked by a monitor.
module tb_board_clock_ctrl;

   localparam int DW  = 8;
   localparam int DEF = 6;
   localparam int NS  = 4;
   localparam int NL  = 4;
   localparam int DB  = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [1:0]    mode;
   logic          div_load;
   logic [DW-1:0] div_value;
   logic          step_btn;
   logic [NS-1:0] switch_raw;
   logic [NL-1:0] led_in;
   logic          cpu_en;
   logic [NS-1:0] sw;
   logic [NL-1:0] led;
   logic [31:0]   en_count;

   always #5 clk = ~clk;

   board_clock_ctrl #(
      .DIV_WIDTH(DW), .DEFAULT_DIV(DEF), .N_SW(NS), .N_LED(NL), .DEBOUNCE_CYCLES(DB)
   ) dut (
      .clk(clk), .reset(reset), .mode(mode), .div_load(div_load), .div_value(div_value),
      .step_btn(step_btn), .switch_raw(switch_raw), .led_in(led_in),
      .cpu_en(cpu_en), .switch(sw), .led(led), .en_count(en_count)
   );

   typedef struct packed {
      logic          en;
      logic [NS-1:0] sw;
      logic [NL-1:0] led;
      logic [31:0]   cnt;
   } obs_t;

   obs_t exp_q[$];
   int   total = 0;
   int   bad = 0;
   bit   started = 0;

   // Reference model: raw input history per edge, debounced step history per edge,
   // and divided-mode pulses as multiples of the ratio since the last restart point.
   int            t = 0;
   logic [NS:0]   hist[$];
   logic          ds[$];
   logic [NS:0]   m_deb;
   logic          m_en;
   logic [31:0]   m_cnt;
   int            m_div;
   int            anchor;
   logic [1:0]    m_prev_mode;
   logic [NL-1:0] m_led;

   task automatic model_step();
      logic [NS:0] raw;
      logic [NS:0] nd;
      logic        se;
      logic        chg;
      logic        en;
      bit          all_diff;
      obs_t        o;
      raw = {switch_raw, step_btn};
      if (reset) begin
         m_en = 1'b0; m_cnt = '0; m_div = DEF; m_deb = '0; anchor = t;
         m_prev_mode = mode; m_led = '0;
         if (t > 0) hist[t-1] = '0;
         hist.push_back('0);
         ds.push_back(1'b0);
      end else begin
         m_cnt = m_cnt + {31'd0, m_en};
         nd = m_deb;
         for (int b = 0; b <= NS; b++) begin
            all_diff = 1;
            for (int e = t - DB + 1; e <= t; e++) begin
               if (e - 2 < 0) all_diff = 0;
               else if (hist[e-2][b] == m_deb[b]) all_diff = 0;
            end
            if (all_diff) nd[b] = hist[t-2][b];
         end
         se  = (t >= 2) && ds[t-1] && !ds[t-2];
         chg = (mode != m_prev_mode);
         case (mode)
            2'd1:    en = se;
            2'd2:    en = !div_load && (((t - anchor) % m_div) == 0);
            2'd3:    en = 1'b1;
            default: en = 1'b0;
         endcase
         if (chg) en = 1'b0;
         if (div_load || chg) anchor = t;
         if (div_load) m_div = (div_value == 0) ? 1 : int'(div_value);
         m_en = en; m_deb = nd; m_prev_mode = mode; m_led = led_in;
         hist.push_back(raw);
         ds.push_back(nd[0]);
      end
      o.en = m_en; o.sw = m_deb[NS:1]; o.led = m_led; o.cnt = m_cnt;
      exp_q.push_back(o);
      t++;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // One clock: randomise LEDs, predict the post-edge outputs, advance to the next falling edge.
   task automatic cyc();
      led_in = NL'($urandom);
      model_step();
      started = 1;
      @(posedge clk);
      @(negedge clk);
   endtask

   // Monitor: compares every post-edge output set against the oldest prediction.
   initial begin
      obs_t e;
      obs_t a;
      int   n;
      n = 0;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a.en = cpu_en; a.sw = sw; a.led = led; a.cnt = en_count;
            total++;
            if (a !== e) begin
               bad++;
               $display("FAIL cycle %0d: got en=%0b sw=%0h led=%0h cnt=%0h want en=%0b sw=%0h led=%0h cnt=%0h",
                        n, a.en, a.sw, a.led, a.cnt, e.en, e.sw, e.led, e.cnt);
            end
         end else if (started) begin
            total++;
            bad++;
            $display("FAIL scoreboard: no prediction for cycle %0d, got en=%0b want a queued entry", n, cpu_en);
         end
         n++;
      end
   end

   initial begin
      logic [31:0] c0;
      int j;
      reset = 1; mode = 2'b10; div_load = 0; div_value = '0;
      step_btn = 0; switch_raw = '0; led_in = '0;
      repeat (3) cyc();
      chk("reset_cnt", en_count, 0);

      // Divide by 5: pulses at load+5, +10, +15, +20.
      reset = 0; div_load = 1; div_value = 8'd5; cyc(); div_load = 0;
      repeat (21) cyc();
      chk("en_count_div5", en_count, 4);

      // Single step: pulse exactly 7 cycles after the raw edge, only once.
      mode = 2'b01; repeat (4) cyc();
      c0 = en_count;
      step_btn = 1;
      for (int k = 1; k <= 20; k++) begin
         cyc();
         if (k == 6) chk("step_early", {31'd0, cpu_en}, 0);
         if (k == 7) chk("step_pulse", {31'd0, cpu_en}, 1);
      end
      step_btn = 0; repeat (8) cyc();
      chk("step_count", en_count - c0, 1);

      // Switch glitch rejected; held level appears 6 cycles after the raw edge.
      switch_raw[2] = 1; repeat (3) cyc(); switch_raw[2] = 0;
      for (int k = 0; k < 10; k++) begin
         cyc();
         chk("glitch_sw2", {31'd0, sw[2]}, 0);
      end
      switch_raw[2] = 1;
      for (int k = 1; k <= 10; k++) begin
         cyc();
         if (k == 5) chk("sw2_early", {31'd0, sw[2]}, 0);
         if (k == 6) chk("sw2_set", {31'd0, sw[2]}, 1);
      end
      switch_raw[2] = 0; repeat (8) cyc();

      // Ratio 0 behaves as 1; reload mid-count suppresses the old-count pulse.
      mode = 2'b10; repeat (3) cyc();
      div_load = 1; div_value = 8'd0; cyc(); div_load = 0;
      chk("load0_no_pulse", {31'd0, cpu_en}, 0);
      for (int k = 0; k < 6; k++) begin
         cyc();
         chk("div1_every", {31'd0, cpu_en}, 1);
      end
      div_load = 1; div_value = 8'd5; cyc(); div_load = 0;
      repeat (4) cyc();
      div_load = 1; div_value = 8'd3; cyc(); div_load = 0;
      chk("load3_no_pulse", {31'd0, cpu_en}, 0);
      cyc(); chk("load3_c1", {31'd0, cpu_en}, 0);
      cyc(); chk("load3_c2", {31'd0, cpu_en}, 0);
      cyc(); chk("load3_c3", {31'd0, cpu_en}, 1);

      // Full speed, counter wrap, halt.
      mode = 2'b11; cyc();
      chk("full_change", {31'd0, cpu_en}, 0);
      for (int k = 0; k < 4; k++) begin
         cyc();
         chk("full_run", {31'd0, cpu_en}, 1);
      end
      force dut.en_count = 32'hFFFF_FFFF;
      m_cnt = 32'hFFFF_FFFF;
      #1 release dut.en_count;
      cyc(); chk("wrap", en_count, 0);
      cyc(); chk("wrap_next", en_count, 1);
      mode = 2'b00; cyc();
      chk("halt", {31'd0, cpu_en}, 0);

      // Step pressed while halted is not replayed in step mode.
      step_btn = 1; repeat (10) cyc();
      c0 = en_count;
      mode = 2'b01; repeat (6) cyc();
      step_btn = 0; repeat (8) cyc();
      chk("no_queued_step", en_count - c0, 0);

      // Reset mid-count and mid-debounce.
      mode = 2'b10; div_load = 1; div_value = 8'd5; switch_raw[1] = 1; cyc(); div_load = 0;
      repeat (3) cyc();
      reset = 1; cyc();
      chk("rst_en", {31'd0, cpu_en}, 0);
      chk("rst_sw", {28'd0, sw}, 0);
      chk("rst_led", {28'd0, led}, 0);
      chk("rst_cnt", en_count, 0);
      reset = 0;
      for (int k = 1; k <= DEF; k++) begin
         cyc();
         if (k == DEF - 1) chk("rst_div_early", {31'd0, cpu_en}, 0);
         if (k == DEF) chk("rst_div_first", {31'd0, cpu_en}, 1);
      end

      // Random traffic across all modes, loads, buttons and occasional resets.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
         div_load  = ($urandom_range(0, 15) == 0);
         div_value = DW'($urandom_range(0, 7));
         if ($urandom_range(0, 9) == 0) step_btn = ~step_btn;
         if ($urandom_range(0, 7) == 0) begin
            j = $urandom_range(0, NS - 1);
            switch_raw[j] = ~switch_raw[j];
         end
         reset = ($urandom_range(0, 99) == 0);
         cyc();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
